fighter_state_ctrl: RTL and testbench



---
 rtl/fighter_state_ctrl.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_fighter_state_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fighter_state_ctrl.sv
// fighter_state_ctrl: per-player pose controller turning debounced buttons and hit pulses
// into position, facing, airborne flag, move_state and character_state for the renderer.
module fighter_state_ctrl #(
    parameter int unsigned TICK_DIV    = 2_500_000,
    parameter int unsigned X_INIT      = 24,
    parameter int unsigned X_MIN       = 8,
    parameter int unsigned X_MAX       = 88,
    parameter int unsigned Y_GROUND    = 32,
    parameter int unsigned JUMP_V      = 6,
    parameter int unsigned PUNCH_TICKS = 15,
    parameter int unsigned SP_TICKS    = 24,
    parameter int unsigned INJ_TICKS   = 20,
    parameter int unsigned COMBO_WIN   = 8,
    parameter bit          MIRROR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_attack,
    input  logic       hit,
    input  logic [6:0] opp_x,
    output logic [6:0] x,
    output logic [6:0] y,
    output logic       in_air,
    output logic [1:0] move_state,
    output logic [2:0] character_state,
    output logic       mirror,
    output logic       attack_active
);

    localparam int unsigned DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TMR_MAX = (PUNCH_TICKS > SP_TICKS)
                                    ? ((PUNCH_TICKS > INJ_TICKS) ? PUNCH_TICKS : INJ_TICKS)
                                    : ((SP_TICKS > INJ_TICKS) ? SP_TICKS : INJ_TICKS);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned WIN_W   = $clog2(COMBO_WIN + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] PUNCH_T  = TMR_W'(PUNCH_TICKS);
    localparam logic [TMR_W-1:0] SP_T     = TMR_W'(SP_TICKS);
    localparam logic [TMR_W-1:0] INJ_T    = TMR_W'(INJ_TICKS);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(COMBO_WIN);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [6:0]       X_INIT_C = 7'(X_INIT);
    localparam logic [6:0]       X_MIN_C  = 7'(X_MIN);
    localparam logic [6:0]       X_MAX_C  = 7'(X_MAX);
    localparam logic [6:0]       Y_GND_C  = 7'(Y_GROUND);
    localparam logic signed [8:0] Y_GND_S = 9'(Y_GROUND);
    localparam logic signed [4:0] JUMP_VY = 5'(JUMP_V);
    localparam logic signed [4:0] VY_MIN  = 5'sb10000;

    localparam logic [1:0] MS_IDLE = 2'b00;
    localparam logic [1:0] MS_FWD  = 2'b01;
    localparam logic [1:0] MS_BACK = 2'b10;

    typedef enum logic [2:0] {
        ST_NORMAL = 3'b000,
        ST_PUNCH  = 3'b001,
        ST_SP0    = 3'b010,
        ST_INJ    = 3'b100
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [4:0]         btn_prev_q;
    logic [1:0]         stage_q, stage_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [6:0]         x_q, x_d;
    logic [6:0]         y_q, y_d;
    logic signed [4:0]  vy_q, vy_d;
    logic               in_air_q, in_air_d;
    logic [1:0]         move_q, move_d;
    logic               mirror_q, mirror_d;
    logic               attack_active_s;

    logic               tick_s;
    logic [4:0]         btn_now_s;
    logic [4:0]         edge_s;
    logic               fwd_edge_s, back_edge_s, down_edge_s, dir_edge_s;
    logic               is_normal_s, hit_go_s, atk_go_s, jump_go_s, move_ok_s;
    logic               advance_s;
    logic signed [8:0]  y_ext_s, vy_ext_s, y_next_s;

    // One pixel step toward inc/dec, held inside the horizontal clamp.
    function automatic logic [6:0] step_x(input logic [6:0] cur, input logic inc);
        logic [6:0] res;
        if (inc) begin
            res = (cur >= X_MAX_C) ? X_MAX_C : (cur + 7'd1);
        end else begin
            res = (cur <= X_MIN_C) ? X_MIN_C : (cur - 7'd1);
        end
        return res;
    endfunction

    assign tick_s      = (div_q == DIV_LAST);
    assign btn_now_s   = {btn_down, btn_up, btn_right, btn_left, btn_attack};
    assign edge_s      = btn_now_s & ~btn_prev_q;
    assign fwd_edge_s  = mirror_q ? edge_s[1] : edge_s[2];
    assign back_edge_s = mirror_q ? edge_s[2] : edge_s[1];
    assign down_edge_s = edge_s[4];
    assign dir_edge_s  = |edge_s[4:1];

    assign is_normal_s = (state_q == ST_NORMAL);
    assign hit_go_s    = hit && (state_q != ST_INJ);
    assign atk_go_s    = is_normal_s && !hit && edge_s[0] && !in_air_q;
    assign jump_go_s   = is_normal_s && !hit && !atk_go_s && edge_s[3] && !in_air_q;
    assign move_ok_s   = is_normal_s && !hit && !atk_go_s && !jump_go_s;
    assign advance_s   = ((stage_q == 2'd0) && back_edge_s) ||
                         ((stage_q == 2'd1) && down_edge_s) ||
                         ((stage_q == 2'd2) && fwd_edge_s);

    assign y_ext_s  = {2'b00, y_q};
    assign vy_ext_s = {{4{vy_q[4]}}, vy_q};
    assign y_next_s = y_ext_s - vy_ext_s;

    // State register: every flop of the controller.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_NORMAL;
            timer_q    <= {TMR_W{1'b0}};
            div_q      <= {DIV_W{1'b0}};
            btn_prev_q <= 5'b00000;
            stage_q    <= 2'd0;
            win_q      <= {WIN_W{1'b0}};
            x_q        <= X_INIT_C;
            y_q        <= Y_GND_C;
            vy_q       <= 5'sd0;
            in_air_q   <= 1'b0;
            move_q     <= MS_IDLE;
            mirror_q   <= MIRROR_INIT;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            div_q      <= div_d;
            btn_prev_q <= btn_now_s;
            stage_q    <= stage_d;
            win_q      <= win_d;
            x_q        <= x_d;
            y_q        <= y_d;
            vy_q       <= vy_d;
            in_air_q   <= in_air_d;
            move_q     <= move_d;
            mirror_q   <= mirror_d;
        end
    end

    // Game-tick divider.
    always_comb begin
        div_d = div_q;
        if (tick_s) begin
            div_d = {DIV_W{1'b0}};
        end else begin
            div_d = div_q + DIV_ONE;
        end
    end

    // Next-state logic: hit beats attack; timed states return to NORMAL on the tick seeing 1.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (hit_go_s) begin
            state_d = ST_INJ;
            timer_d = INJ_T;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    if (atk_go_s && (stage_q == 2'd3)) begin
                        state_d = ST_SP0;
                        timer_d = SP_T;
                    end else if (atk_go_s) begin
                        state_d = ST_PUNCH;
                        timer_d = PUNCH_T;
                    end else begin
                        state_d = ST_NORMAL;
                        timer_d = timer_q;
                    end
                end
                ST_PUNCH, ST_SP0, ST_INJ: begin
                    if (tick_s && (timer_q <= TMR_ONE)) begin
                        state_d = ST_NORMAL;
                        timer_d = {TMR_W{1'b0}};
                    end else if (tick_s) begin
                        timer_d = timer_q - TMR_ONE;
                    end else begin
                        timer_d = timer_q;
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                    timer_d = {TMR_W{1'b0}};
                end
            endcase
        end
    end

    // Combo tracker: back, down, forward within the window arms the special.
    always_comb begin
        stage_d = stage_q;
        win_d   = win_q;
        if (hit_go_s || (atk_go_s && (stage_q == 2'd3))) begin
            stage_d = 2'd0;
            win_d   = {WIN_W{1'b0}};
        end else if (is_normal_s) begin
            if (advance_s) begin
                stage_d = stage_q + 2'd1;
                win_d   = WIN_LOAD;
            end else if (dir_edge_s && back_edge_s) begin
                stage_d = 2'd1;
                win_d   = WIN_LOAD;
            end else if (dir_edge_s) begin
                stage_d = 2'd0;
                win_d   = {WIN_W{1'b0}};
            end else if (tick_s && (win_q != {WIN_W{1'b0}})) begin
                win_d   = win_q - WIN_ONE;
                stage_d = (win_q == WIN_ONE) ? 2'd0 : stage_q;
            end else begin
                stage_d = stage_q;
                win_d   = win_q;
            end
        end else begin
            stage_d = stage_q;
            win_d   = win_q;
        end
    end

    // Motion: jump launch, gravity, horizontal stepping, knock-back and facing.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        vy_d     = vy_q;
        in_air_d = in_air_q;
        move_d   = move_q;
        mirror_d = mirror_q;
        if (jump_go_s) begin
            in_air_d = 1'b1;
            vy_d     = JUMP_VY;
        end else if (tick_s && in_air_q) begin
            if (y_next_s >= Y_GND_S) begin
                y_d      = Y_GND_C;
                in_air_d = 1'b0;
                vy_d     = 5'sd0;
            end else if (y_next_s < 9'sd0) begin
                y_d  = 7'd0;
                vy_d = (vy_q == VY_MIN) ? vy_q : (vy_q - 5'sd1);
            end else begin
                y_d  = y_next_s[6:0];
                vy_d = (vy_q == VY_MIN) ? vy_q : (vy_q - 5'sd1);
            end
        end else begin
            in_air_d = in_air_q;
        end
        if (tick_s && move_ok_s) begin
            mirror_d = (opp_x < x_q);
            if (btn_left ^ btn_right) begin
                x_d    = step_x(x_q, btn_right);
                move_d = (btn_right ^ mirror_q) ? MS_FWD : MS_BACK;
            end else begin
                move_d = MS_IDLE;
            end
        end else if (tick_s && (state_q == ST_INJ)) begin
            move_d = MS_IDLE;
            x_d    = step_x(x_q, (opp_x < x_q) || ((opp_x == x_q) && mirror_q));
        end else if (tick_s) begin
            move_d = MS_IDLE;
        end else begin
            move_d = move_q;
        end
    end

    // Output decode: attack is live in either striking state.
    always_comb begin
        attack_active_s = 1'b0;
        case (state_q)
            ST_PUNCH, ST_SP0: attack_active_s = 1'b1;
            default:          attack_active_s = 1'b0;
        endcase
    end

    assign x               = x_q;
    assign y               = y_q;
    assign in_air          = in_air_q;
    assign move_state      = move_q;
    assign character_state = state_q;
    assign mirror          = mirror_q;
    assign attack_active   = attack_active_s;

endmodule

// File: tb/tb_fighter_state_ctrl.sv
// Directed bench for fighter_state_ctrl with a 4-cycle game tick; all stimulus keeps tick phase.
module tb_fighter_state_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_left, btn_right, btn_up, btn_down, btn_attack, hit;
    logic [6:0] opp_x;
    logic [6:0] x, y;
    logic       in_air, mirror, attack_active;
    logic [1:0] move_state;
    logic [2:0] character_state;

    int vectors = 0;
    int miscompares = 0;

    fighter_state_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
        .btn_down(btn_down), .btn_attack(btn_attack), .hit(hit), .opp_x(opp_x),
        .x(x), .y(y), .in_air(in_air), .move_state(move_state),
        .character_state(character_state), .mirror(mirror), .attack_active(attack_active)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0;
        btn_down = 1'b0; btn_attack = 1'b0; hit = 1'b0; opp_x = 7'd60;
        cyc(3);
        reset = 1'b0;
        vectors++;
        if ({x, y, in_air, move_state, character_state, mirror, attack_active} !==
            {7'd24, 7'd32, 1'b0, 2'b00, 3'b000, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_pose: got x=%0d y=%0d air=%b ms=%b cs=%b mir=%b aa=%b expected x=24 y=32 all else 0",
                     x, y, in_air, move_state, character_state, mirror, attack_active);
        end
    endtask

    task automatic test_move();
        btn_right = 1'b1;
        cyc(12);
        vectors++;
        if ({x, move_state} !== {7'd27, 2'b01}) begin
            miscompares++;
            $display("FAIL move_right: got x=%0d ms=%b expected x=27 ms=01", x, move_state);
        end
        btn_right = 1'b0; btn_left = 1'b1;
        cyc(4);
        vectors++;
        if ({x, move_state} !== {7'd26, 2'b10}) begin
            miscompares++;
            $display("FAIL move_left: got x=%0d ms=%b expected x=26 ms=10", x, move_state);
        end
        btn_right = 1'b1;
        cyc(4);
        vectors++;
        if ({x, move_state} !== {7'd26, 2'b00}) begin
            miscompares++;
            $display("FAIL move_both: got x=%0d ms=%b expected x=26 ms=00", x, move_state);
        end
        btn_left = 1'b0; btn_right = 1'b0;
        cyc(4);
    endtask

    task automatic test_jump();
        logic [6:0] exp_y [0:12];
        exp_y = '{7'd26, 7'd21, 7'd17, 7'd14, 7'd12, 7'd11, 7'd11,
                  7'd12, 7'd14, 7'd17, 7'd21, 7'd26, 7'd32};
        btn_up = 1'b1;
        cyc(1);
        vectors++;
        if ({in_air, y} !== {1'b1, 7'd32}) begin
            miscompares++;
            $display("FAIL jump_launch: got air=%b y=%0d expected air=1 y=32", in_air, y);
        end
        btn_up = 1'b0;
        cyc(3);
        for (int i = 0; i < 13; i++) begin
            if (i == 4) btn_up = 1'b1;
            if (i == 6) btn_up = 1'b0;
            if (i > 0) cyc(4);
            vectors++;
            if ({y, in_air} !== {exp_y[i], (i < 12)}) begin
                miscompares++;
                $display("FAIL jump_tick%0d: got y=%0d air=%b expected y=%0d air=%b",
                         i + 1, y, in_air, exp_y[i], (i < 12));
            end
        end
        vectors++;
        if (x !== 7'd26) begin
            miscompares++;
            $display("FAIL jump_x: got x=%0d expected 26", x);
        end
    endtask

    task automatic test_punch();
        btn_attack = 1'b1; btn_right = 1'b1;
        cyc(1);
        vectors++;
        if ({character_state, attack_active} !== {3'b001, 1'b1}) begin
            miscompares++;
            $display("FAIL punch_enter: got cs=%b aa=%b expected cs=001 aa=1", character_state, attack_active);
        end
        btn_attack = 1'b0;
        cyc(3);
        for (int k = 1; k <= 15; k++) begin
            if (k > 1) cyc(4);
            vectors++;
            if ({character_state, x, move_state} !== {((k < 15) ? 3'b001 : 3'b000), 7'd26, 2'b00}) begin
                miscompares++;
                $display("FAIL punch_tick%0d: got cs=%b x=%0d ms=%b expected cs=%b x=26 ms=00",
                         k, character_state, x, move_state, ((k < 15) ? 3'b001 : 3'b000));
            end
        end
        cyc(56);
        vectors++;
        if ({x, move_state} !== {7'd40, 2'b01}) begin
            miscompares++;
            $display("FAIL punch_after_move: got x=%0d ms=%b expected x=40 ms=01", x, move_state);
        end
        btn_right = 1'b0; opp_x = 7'd50;
        cyc(4);
    endtask

    task automatic test_injured();
        btn_attack = 1'b1;
        cyc(1);
        btn_attack = 1'b0;
        cyc(3);
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        vectors++;
        if ({character_state, attack_active, x} !== {3'b100, 1'b0, 7'd40}) begin
            miscompares++;
            $display("FAIL inj_enter: got cs=%b aa=%b x=%0d expected cs=100 aa=0 x=40",
                     character_state, attack_active, x);
        end
        cyc(3);
        for (int k = 1; k <= 20; k++) begin
            if (k == 6) begin
                hit = 1'b1; cyc(1); hit = 1'b0; cyc(3);
            end else if (k > 1) begin
                cyc(4);
            end
            vectors++;
            if ({character_state, x} !== {((k < 20) ? 3'b100 : 3'b000), 7'(40 - k)}) begin
                miscompares++;
                $display("FAIL inj_tick%0d: got cs=%b x=%0d expected cs=%b x=%0d",
                         k, character_state, x, ((k < 20) ? 3'b100 : 3'b000), 40 - k);
            end
        end
    endtask

    task automatic test_hit_and_attack();
        btn_attack = 1'b1; hit = 1'b1;
        cyc(1);
        hit = 1'b0; btn_attack = 1'b0;
        vectors++;
        if (character_state !== 3'b100) begin
            miscompares++;
            $display("FAIL hit_vs_attack: got cs=%b expected 100", character_state);
        end
        cyc(79);
        vectors++;
        if ({character_state, x} !== {3'b000, 7'd8}) begin
            miscompares++;
            $display("FAIL knockback_clamp: got cs=%b x=%0d expected cs=000 x=8", character_state, x);
        end
    endtask

    task automatic test_hit_at_punch_end();
        btn_attack = 1'b1;
        cyc(1);
        btn_attack = 1'b0;
        cyc(55);
        vectors++;
        if (character_state !== 3'b001) begin
            miscompares++;
            $display("FAIL punch_tick14: got cs=%b expected 001", character_state);
        end
        cyc(3);
        hit = 1'b1;
        cyc(1);
        hit = 1'b0;
        vectors++;
        if (character_state !== 3'b100) begin
            miscompares++;
            $display("FAIL hit_on_punch_end: got cs=%b expected 100", character_state);
        end
        cyc(80);
        vectors++;
        if (character_state !== 3'b000) begin
            miscompares++;
            $display("FAIL inj_after_punch_end: got cs=%b expected 000", character_state);
        end
    endtask

    task automatic test_combo_special();
        btn_left = 1'b1;
        cyc(4);
        vectors++;
        if ({x, move_state, mirror} !== {7'd8, 2'b10, 1'b0}) begin
            miscompares++;
            $display("FAIL left_clamp: got x=%0d ms=%b mir=%b expected x=8 ms=10 mir=0", x, move_state, mirror);
        end
        btn_left = 1'b0; btn_down = 1'b1;
        cyc(4);
        btn_down = 1'b0; btn_right = 1'b1;
        cyc(1);
        btn_right = 1'b0;
        cyc(3);
        btn_attack = 1'b1;
        cyc(1);
        btn_attack = 1'b0;
        vectors++;
        if ({character_state, attack_active} !== {3'b010, 1'b1}) begin
            miscompares++;
            $display("FAIL special_enter: got cs=%b aa=%b expected cs=010 aa=1", character_state, attack_active);
        end
        cyc(91);
        vectors++;
        if (character_state !== 3'b010) begin
            miscompares++;
            $display("FAIL special_tick23: got cs=%b expected 010", character_state);
        end
        cyc(4);
        vectors++;
        if (character_state !== 3'b000) begin
            miscompares++;
            $display("FAIL special_end: got cs=%b expected 000", character_state);
        end
    endtask

    task automatic test_combo_timeout();
        btn_left = 1'b1; cyc(1); btn_left = 1'b0; cyc(3);
        btn_down = 1'b1; cyc(1); btn_down = 1'b0; cyc(3);
        cyc(32);
        btn_right = 1'b1; cyc(1); btn_right = 1'b0;
        btn_attack = 1'b1; cyc(1); btn_attack = 1'b0;
        vectors++;
        if (character_state !== 3'b001) begin
            miscompares++;
            $display("FAIL combo_timeout: got cs=%b expected 001", character_state);
        end
        cyc(58);
        vectors++;
        if (character_state !== 3'b000) begin
            miscompares++;
            $display("FAIL timeout_punch_end: got cs=%b expected 000", character_state);
        end
    endtask

    task automatic test_reset_midjump();
        btn_up = 1'b1; cyc(1); btn_up = 1'b0;
        cyc(7);
        vectors++;
        if ({in_air, y} !== {1'b1, 7'd21}) begin
            miscompares++;
            $display("FAIL midjump_y: got air=%b y=%0d expected air=1 y=21", in_air, y);
        end
        reset = 1'b1; cyc(1); reset = 1'b0;
        vectors++;
        if ({x, y, in_air, character_state, move_state} !== {7'd24, 7'd32, 1'b0, 3'b000, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_midjump: got x=%0d y=%0d air=%b cs=%b ms=%b expected x=24 y=32 air=0 cs=000 ms=00",
                     x, y, in_air, character_state, move_state);
        end
        opp_x = 7'd10;
        cyc(4);
        vectors++;
        if (mirror !== 1'b1) begin
            miscompares++;
            $display("FAIL mirror_set: got %b expected 1", mirror);
        end
        btn_right = 1'b1;
        cyc(4);
        btn_right = 1'b0;
        vectors++;
        if ({x, move_state} !== {7'd25, 2'b10}) begin
            miscompares++;
            $display("FAIL mirrored_back: got x=%0d ms=%b expected x=25 ms=10", x, move_state);
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_jump();
        test_punch();
        test_injured();
        test_hit_and_attack();
        test_hit_at_punch_end();
        test_combo_special();
        test_combo_timeout();
        test_reset_midjump();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
